// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator for the data-memory responder port
// One request at a time: IDLE -> ACCESS -> RESP, or IDLE -> RESP on a misaligned/illegal request.
module lsu_mem_master #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_suffix_b,
    output logic              mem_suffix_h,
    output logic              mem_sext,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fault;
    logic             access_done;

    always_comb begin
        fault = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    // The registered strobes double as the latched request while in ACCESS.
    always_comb begin
        access_done = mem_wen | (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_fault   <= 1'b0;
            mem_ren      <= 1'b0;
            mem_raddr    <= '0;
            mem_wen      <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            mem_suffix_b <= 1'b0;
            mem_suffix_h <= 1'b0;
            mem_sext     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        cnt        <= '0;
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state        <= ACCESS;
                            resp_fault   <= 1'b0;
                            mem_ren      <= ~req_wen;
                            mem_wen      <= req_wen;
                            mem_raddr    <= req_addr;
                            mem_waddr    <= req_addr;
                            mem_wdata    <= req_wen ? req_wdata : 32'h0;
                            mem_suffix_b <= (req_size == 2'b00);
                            mem_suffix_h <= (req_size == 2'b01);
                            mem_sext     <= req_sext & ~req_wen;
                        end
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        if (!mem_wen) begin
                            resp_rdata <= mem_rdata;
                        end
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        mem_ren      <= 1'b0;
                        mem_wen      <= 1'b0;
                        mem_raddr    <= '0;
                        mem_waddr    <= '0;
                        mem_wdata    <= '0;
                        mem_suffix_b <= 1'b0;
                        mem_suffix_h <= 1'b0;
                        mem_sext     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed and random load/store checks against a byte-array memory model
module tb_lsu_mem_master;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_suffix_b(mem_suffix_b), .mem_suffix_h(mem_suffix_h),
        .mem_sext(mem_sext), .mem_rdata(mem_rdata)
    );

    // Word-organised memory responder: writes on negedge, read data presented on negedge.
    logic [31:0] mem_w [bit [29:0]];

    always @(negedge clk) begin : mem_resp
        logic [31:0] w;
        int sh;
        if (mem_wen) begin
            w  = mem_w.exists(mem_waddr[31:2]) ? mem_w[mem_waddr[31:2]] : 32'h0;
            sh = 8 * int'(mem_waddr[1:0]);
            if (mem_suffix_b)      w[sh +: 8]  = mem_wdata[7:0];
            else if (mem_suffix_h) w[sh +: 16] = mem_wdata[15:0];
            else                   w = mem_wdata;
            mem_w[mem_waddr[31:2]] = w;
        end
        if (mem_ren) begin
            w = mem_w.exists(mem_raddr[31:2]) ? mem_w[mem_raddr[31:2]] : 32'h0;
            w = w >> (8 * int'(mem_raddr[1:0]));
            if (mem_suffix_b)      w = mem_sext ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            else if (mem_suffix_h) w = mem_sext ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            mem_rdata <= w;
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Reference model: flat byte-addressed memory.
    logic [7:0] ref_b [bit [31:0]];

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic sext);
        longint v = 0;
        int n = 1 << size;
        for (int i = 0; i < n; i++)
            v += longint'(ref_b.exists(32'(a + i)) ? ref_b[32'(a + i)] : 8'h0) << (8 * i);
        if (sext && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sext, input int hold);
        logic        flt;
        logic [31:0] exp_rdata;
        int ren_n, wen_n, both_n, cyc, exp_cyc;
        flt = (size == 2'b11) || ((addr % (32'd1 << size)) != 0);
        exp_rdata = (flt || wen) ? 32'h0 : ref_load(addr, size, sext);
        exp_cyc = flt ? 0 : (wen ? 1 : LAT);
        if (!flt && wen)
            for (int i = 0; i < (1 << size); i++) ref_b[32'(addr + i)] = wdata[8*i +: 8];

        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_sext = sext;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        ren_n = 0; wen_n = 0; both_n = 0; cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            if (mem_ren === 1'b1) ren_n++;
            if (mem_wen === 1'b1) wen_n++;
            if (mem_ren === 1'b1 && mem_wen === 1'b1) both_n++;
            chk("access_raddr", mem_raddr, addr);
            chk("access_waddr", mem_waddr, addr);
            chk("access_suffix_b", 32'(mem_suffix_b), 32'(size == 2'b00));
            chk("access_suffix_h", 32'(mem_suffix_h), 32'(size == 2'b01));
            chk("access_sext", 32'(mem_sext), 32'(sext & ~wen));
            chk("access_wdata", mem_wdata, wen ? wdata : 32'h0);
            chk("access_req_ready", 32'(req_ready), 32'd0);
            cyc++;
            @(negedge clk);
        end
        chk("resp_timeout", 32'(cyc < 20), 32'd1);
        chk("access_cycles", 32'(cyc), 32'(exp_cyc));
        chk("ren_cycles", 32'(ren_n), 32'((!flt && !wen) ? LAT : 0));
        chk("wen_cycles", 32'(wen_n), 32'((!flt && wen) ? 1 : 0));
        chk("ren_wen_overlap", 32'(both_n), 32'd0);

        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_fault", 32'(resp_fault), 32'(flt));
            chk("resp_mem_quiet", {mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext}, 32'd0);
            chk("resp_mem_addr", mem_raddr | mem_waddr | mem_wdata, 32'd0);
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            // Offer a competing request while the response is stalled; it must be ignored.
            req_valid  = (h < hold);
            resp_ready = (h == hold);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_sext = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp", resp_rdata | 32'(resp_fault), 32'd0);
        chk("rst_mem_strobes", {mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext}, 32'd0);
        chk("rst_mem_buses", mem_raddr | mem_waddr | mem_wdata, 32'd0);
        rst = 1'b0;

        do_op(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
        do_op(1'b1, 32'h8000_0013, 32'h0000_0080, 2'b00, 1'b0, 1);
        do_op(1'b0, 32'h8000_0013, 32'h0, 2'b00, 1'b1, 0);
        chk("byte_sext_result", resp_rdata, 32'hFFFF_FF80);
        do_op(1'b0, 32'h8000_0001, 32'h0, 2'b01, 1'b0, 0);
        do_op(1'b0, 32'h8000_0010, 32'h0, 2'b11, 1'b0, 0);
        do_op(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 4);

        // Reset on the second ACCESS cycle of a load.
        req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'b10; req_sext = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_ren_c1", 32'(mem_ren), 32'd1);
        @(negedge clk);
        chk("abort_ren_c2", 32'(mem_ren), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ren_off", 32'(mem_ren), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
            chk("abort_no_strobe", 32'(mem_ren | mem_wen), 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), 32'h8000_0000 + $urandom_range(0, 31), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
